// File: rtl/twos_comp.sv
// Registered two's-complement adder/subtractor built on one ripple-carry chain.
// Subtraction adds the inverted B operand with a carry-in of one.
module twos_comp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub_en,
    output logic [WIDTH-1:0] OUT,
    output logic             Cout,
    output logic             overflow
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {co, s};
    endfunction

    logic [WIDTH-1:0] bx_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   carry_s;
    logic [1:0]       cell_s;
    logic             ovf_s;

    // Operand conditioning: invert B when subtracting.
    always_comb begin
        bx_s = {WIDTH{1'b0}};
        if (sub_en) begin
            bx_s = ~B;
        end else begin
            bx_s = B;
        end
    end

    // Ripple-carry chain; carry_s[WIDTH-1] is the carry into the sign bit.
    always_comb begin
        sum_s      = {WIDTH{1'b0}};
        carry_s    = {(WIDTH+1){1'b0}};
        cell_s     = 2'b00;
        carry_s[0] = sub_en;
        for (int i = 0; i < WIDTH; i++) begin
            cell_s         = full_add(A[i], bx_s[i], carry_s[i]);
            sum_s[i]       = cell_s[0];
            carry_s[i+1]   = cell_s[1];
        end
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    always_comb begin
        ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    end

    // Result registers; reset clears all outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT      <= {WIDTH{1'b0}};
            Cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            OUT      <= sum_s;
            Cout     <= carry_s[WIDTH];
            overflow <= ovf_s;
        end
    end

endmodule

// File: tb/tb_twos_comp.sv
// Bench for twos_comp: arithmetic model, per-cycle comparator and directed
// vectors with literal expectations.
module tb_twos_comp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        sub_en = 1'b0;
    logic [15:0] OUT;
    logic        Cout;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b1;

    twos_comp #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sub_en(sub_en),
        .OUT(OUT), .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference from plain integer arithmetic: returns {overflow, cout, out}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int ua, ub, sa, sb, ures, sres;
        logic c, v;
        logic [15:0] o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures > 65535);
        end
        o = ures[15:0];
        v = (sres > 32767) || (sres < -32768);
        return {v, c, o};
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got ovf=%b cout=%b out=%h, want ovf=%b cout=%b out=%h",
                     name, got[17], got[16], got[15:0], want[17], want[16], want[15:0]);
        end
    endtask

    // Per-cycle comparator: inputs captured at each edge must appear one edge later.
    always @(posedge clk) begin
        logic [15:0] a_c, b_c;
        logic s_c, r_c;
        a_c = A; b_c = B; s_c = sub_en; r_c = rst;
        #1;
        if (cmp_on) begin
            if (r_c) check("cycle_reset", {overflow, Cout, OUT}, 18'h0);
            else     check("cycle_model", {overflow, Cout, OUT}, model(a_c, b_c, s_c));
        end
    end

    // Directed vector: pin the model to the literal, then the DUT to the literal.
    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] eo, input logic ec, input logic ev);
        @(negedge clk);
        A = a; B = b; sub_en = s;
        check({name, "_model"}, model(a, b, s), {ev, ec, eo});
        @(posedge clk);
        #2;
        check({name, "_dut"}, {overflow, Cout, OUT}, {ev, ec, eo});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_held", {overflow, Cout, OUT}, 18'h0);
        rst = 1'b0;

        apply("sub_100_4", 16'd100, 16'd4, 1'b1, 16'h0060, 1'b1, 1'b0);

        // Async reset mid-cycle with A=B=4 applied.
        @(negedge clk);
        A = 16'd4; B = 16'd4; sub_en = 1'b1;
        #2 rst = 1'b1;
        #1 check("reset_async", {overflow, Cout, OUT}, 18'h0);
        @(posedge clk);
        #2 check("reset_hold_edge", {overflow, Cout, OUT}, 18'h0);
        @(negedge clk);
        rst = 1'b0;

        apply("sub_eq",        16'd4,     16'd4,     1'b1, 16'h0000, 1'b1, 1'b0);
        apply("sub_100_4b",    16'd100,   16'd4,     1'b1, 16'h0060, 1'b1, 1'b0);
        apply("sub_100_200",   16'd100,   16'd200,   1'b1, 16'hFF9C, 1'b0, 1'b0);
        apply("sub_max_200",   16'h7FFF,  16'd200,   1'b1, 16'h7F37, 1'b1, 1'b0);
        apply("sub_max_1",     16'h7FFF,  16'd1,     1'b1, 16'h7FFE, 1'b1, 1'b0);
        apply("sub_min_1",     16'h8000,  16'd1,     1'b1, 16'h7FFF, 1'b1, 1'b1);
        apply("sub_min_min",   16'h8000,  16'h8000,  1'b1, 16'h0000, 1'b1, 1'b0);
        apply("sub_0_min",     16'h0000,  16'h8000,  1'b1, 16'h8000, 1'b0, 1'b1);
        apply("add_min_min",   16'h8000,  16'h8000,  1'b0, 16'h0000, 1'b1, 1'b1);
        apply("add_min_200",   16'h8000,  16'd200,   1'b0, 16'h80C8, 1'b0, 1'b0);
        apply("add_100_200",   16'd100,   16'd200,   1'b0, 16'h012C, 1'b0, 1'b0);
        apply("add_max_1",     16'h7FFF,  16'd1,     1'b0, 16'h8000, 1'b0, 1'b1);
        apply("add_ffff_1",    16'hFFFF,  16'd1,     1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back changes including sub_en-only flips.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                A = 16'(i * 4099);
                B = 16'(i * 777 + 3);
            end
            sub_en = ~sub_en;
        end

        // Random vectors, with the corner values mixed in.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0:       A = 16'h8000;
                1:       A = 16'h7FFF;
                default: A = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       B = 16'h8000;
                1:       B = A;
                default: B = 16'($urandom);
            endcase
            sub_en = 1'($urandom);
        end

        @(posedge clk);
        #3;
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
